// File: rtl/keypad_if.sv
// keypad_if: keypad matrix pins plus decoded key/number outputs
// master: scanner side (drives columns and results, reads rows)
// slave:  keypad/consumer side (drives rows, reads columns and results)
interface keypad_if;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] number_out;
   modport master (input row_n, output col_n, key_code, key_valid, key_held, number_out);
   modport slave  (output row_n, input col_n, key_code, key_valid, key_held, number_out);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce, key events and decimal entry
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   kp     keypad_if.master: row_n in; col_n, key_code, key_valid, key_held, number_out out
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-issue key_valid while one key stays held
module keypad_scanner #(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int MAX_VALUE      = 9999
`ifdef KEYPAD_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY   = 500,
   parameter int REPEAT_RATE    = 100
`endif
) (
   input logic      clk,
   input logic      reset,
   keypad_if.master kp
);
   localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
   // nibble i holds the key code of raw bit i = col*4 + row
   localparam logic [63:0] CODES = 64'hDCBA_E963_F852_0741;
   logic [3:0]    r_sync1, r_sync2;
   logic [DW-1:0] r_dwell;
   logic [1:0]    r_col;
   logic [15:0]   r_raw, r_prev, r_deb, w_raw_n;
   logic [SW-1:0] r_stable, w_stable_n;
   logic          r_ghost, r_held, r_valid;
   logic [3:0]    r_code, w_code, w_ev_code, w_idx;
   logic [15:0]   r_num, w_num_n;
   logic [17:0]   w_v;
   logic [4:0]    w_cnt;
   logic          w_tc, w_end, w_load, w_one, w_press, w_held_n, w_ghost_n, w_rep, w_ev;
   // full-scan image: columns 0-2 already captured this scan, column 3 sampled now
   always_comb begin
      w_raw_n = r_raw;
      w_raw_n[{r_col, 2'b00} +: 4] = ~r_sync2;
      w_cnt = '0;
      w_idx = '0;
      for (int i = 0; i < 16; i++) begin
         w_cnt = w_cnt + 5'(w_raw_n[i]);
         w_idx = w_raw_n[i] ? 4'(i) : w_idx;
      end
   end
   assign w_tc       = r_dwell == DW'(SCAN_DIV - 1);
   assign w_end      = w_tc && r_col == 2'd3;
   assign w_stable_n = (w_raw_n != r_prev) ? SW'(1) :
                       (r_stable == SW'(DEBOUNCE_SCANS)) ? r_stable : r_stable + 1'b1;
   assign w_load     = w_end && w_stable_n == SW'(DEBOUNCE_SCANS);
   assign w_one      = w_cnt == 5'd1;
   assign w_code     = CODES[{w_idx, 2'b00} +: 4];
   assign w_press    = w_load && w_one && r_deb == '0;
   // ghosting latches until the matrix is completely released
   assign w_ghost_n  = w_load ? (w_cnt > 5'd1) | (r_ghost & (w_cnt != '0)) : r_ghost;
   assign w_held_n   = w_load ? w_one & ~r_ghost : r_held;
`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int HW = $clog2(REPEAT_DELAY + 1);
   logic [HW-1:0] r_hold, w_hold_inc;
   assign w_hold_inc = r_hold + 1'b1;
   assign w_rep      = w_end && r_held && w_held_n && w_hold_inc == HW'(REPEAT_DELAY);
   // after a repeat the counter rewinds so the next one lands REPEAT_RATE scans later
   always_ff @(posedge clk) begin
      if (reset || (w_end && !(r_held && w_held_n)))
         r_hold <= '0;
      else if (w_end)
         r_hold <= w_rep ? HW'(REPEAT_DELAY - REPEAT_RATE) : w_hold_inc;
   end
`else
   assign w_rep = 1'b0;
`endif
   assign w_ev      = w_press | w_rep;
   assign w_ev_code = w_press ? w_code : r_code;
   assign w_v       = 18'(r_num) * 18'd10 + 18'(w_ev_code);
   assign w_num_n   = (w_ev_code <= 4'd9) ? ((w_v <= 18'(MAX_VALUE)) ? w_v[15:0] : r_num) :
                      (w_ev_code == 4'hC) ? '0 :
                      (w_ev_code == 4'hD) ? r_num / 16'd10 : r_num;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1  <= 4'hF;
         r_sync2  <= 4'hF;
         r_dwell  <= '0;
         r_col    <= '0;
         r_raw    <= '0;
         r_prev   <= '0;
         r_deb    <= '0;
         r_stable <= '0;
         r_ghost  <= 1'b0;
         r_held   <= 1'b0;
         r_valid  <= 1'b0;
         r_code   <= '0;
         r_num    <= '0;
      end else begin
         r_sync1 <= kp.row_n;
         r_sync2 <= r_sync1;
         r_dwell <= w_tc ? '0 : r_dwell + 1'b1;
         r_valid <= w_ev;
         r_ghost <= w_ghost_n;
         r_held  <= w_held_n;
         if (w_tc) begin
            r_raw <= w_raw_n;
            r_col <= r_col + 1'b1;
         end
         if (w_end) begin
            r_prev   <= w_raw_n;
            r_stable <= w_stable_n;
         end
         if (w_load)
            r_deb <= w_raw_n;
         if (w_ev) begin
            r_code <= w_ev_code;
            r_num  <= w_num_n;
         end
      end
   end
   assign kp.col_n      = ~(4'b0001 << r_col);
   assign kp.key_code   = r_code;
   assign kp.key_valid  = r_valid;
   assign kp.key_held   = r_held;
   assign kp.number_out = r_num;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=2)
// Models the physical keypad; define KEYPAD_AUTOREPEAT_EN to add the auto-repeat steps
module tb_keypad_scanner;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] pk [4];
   logic [3:0] last_code;
   logic [3:0] e;
   int         checks = 0, errors = 0, cyc = 0, nv = 0;
   int         stamp [64];
   int         b, p, w;
   int         rr [5] = '{0, 0, 0, 1, 1};
   int         cc [5] = '{0, 1, 2, 0, 1};
   int         ex [5] = '{1, 12, 123, 1234, 1234};
   keypad_if kif ();
   keypad_scanner #(
      .SCAN_DIV(4), .DEBOUNCE_SCANS(2), .MAX_VALUE(9999)
`ifdef KEYPAD_AUTOREPEAT_EN
      , .REPEAT_DELAY(3), .REPEAT_RATE(2)
`endif
   ) dut (.clk(clk), .reset(reset), .kp(kif));
   always #5 clk = ~clk;
   // a row reads low when any pressed key in it sits on the driven column
   always_comb begin
      for (int r = 0; r < 4; r++)
         kif.row_n[r] = ~|(pk[r] & ~kif.col_n);
   end
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (kif.key_valid) begin
         stamp[nv % 64] <= cyc;
         nv <= nv + 1;
         last_code <= kif.key_code;
      end
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic scans(input int n);
      repeat (n * 16) @(negedge clk);
   endtask
   task automatic tap(input int r, input int c, output int cnt);
      int b0;
      b0 = nv;
      pk[r][c] = 1'b1;
      scans(4);
      pk[r][c] = 1'b0;
      scans(4);
      cnt = nv - b0;
   endtask
   initial begin
      for (int r = 0; r < 4; r++) pk[r] = '0;
      repeat (3) @(negedge clk);
      chk("rst_col", kif.col_n, 4'b1110);
      chk("rst_code", kif.key_code, 0);
      chk("rst_valid", kif.key_valid, 0);
      chk("rst_held", kif.key_held, 0);
      chk("rst_num", kif.number_out, 0);
      reset = 1'b0;
      for (int k = 0; k < 16; k++) begin
         e = ~(4'b0001 << (k / 4));
         chk("scan_col", kif.col_n, e);
         @(negedge clk);
      end
      b = nv;
      scans(4);
      chk("idle_valid", nv - b, 0);
      chk("idle_num", kif.number_out, 0);
      b = nv;
      pk[2][0] = 1'b1;
      scans(5);
      chk("p7_count", nv - b, 1);
      chk("p7_code", last_code, 7);
      chk("p7_held", kif.key_held, 1);
      chk("p7_num", kif.number_out, 7);
      pk[2][0] = 1'b0;
      scans(4);
      chk("p7_rel_held", kif.key_held, 0);
      chk("p7_rel_count", nv - b, 1);
      tap(2, 3, p);
      chk("clear_num", kif.number_out, 0);
      for (int i = 0; i < 5; i++) begin
         tap(rr[i], cc[i], p);
         chk("digit_count", p, 1);
         chk("digit_num", kif.number_out, ex[i]);
      end
      chk("over_code", last_code, 5);
      tap(3, 3, p);
      chk("bksp_code", last_code, 4'hD);
      chk("bksp_num", kif.number_out, 123);
      b = nv;
      pk[1] = 4'b0011;
      scans(5);
      chk("ghost_count", nv - b, 0);
      chk("ghost_held", kif.key_held, 0);
      pk[1] = 4'b0010;
      scans(5);
      chk("ghost_one_count", nv - b, 0);
      chk("ghost_one_held", kif.key_held, 0);
      pk[1] = 4'b0000;
      scans(4);
      tap(1, 2, p);
      chk("fresh_count", p, 1);
      chk("fresh_code", last_code, 6);
      chk("fresh_num", kif.number_out, 1236);
      b = nv;
      repeat (6) begin
         pk[2][2] = ~pk[2][2];
         scans(1);
      end
      scans(4);
      chk("bounce_count", nv - b, 0);
      chk("bounce_num", kif.number_out, 1236);
      w = 0;
      while (kif.col_n !== 4'b1011 && w < 64) begin
         @(negedge clk);
         w++;
      end
      chk("col2_seen", kif.col_n, 4'b1011);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_col", kif.col_n, 4'b1110);
      chk("mid_rst_num", kif.number_out, 0);
      chk("mid_rst_held", kif.key_held, 0);
      chk("mid_rst_code", kif.key_code, 0);
      reset = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      scans(2);
      b = nv;
      pk[0][0] = 1'b1;
      scans(14);
      pk[0][0] = 1'b0;
      scans(4);
      chk("rep_count_ge5", (nv - b) >= 5, 1);
      chk("rep_gap1", stamp[(b + 1) % 64] - stamp[b % 64], 48);
      chk("rep_gap2", stamp[(b + 2) % 64] - stamp[(b + 1) % 64], 32);
      chk("rep_gap3", stamp[(b + 3) % 64] - stamp[(b + 2) % 64], 32);
      chk("rep_gap4", stamp[(b + 4) % 64] - stamp[(b + 3) % 64], 32);
      chk("rep_code", last_code, 1);
      chk("rep_num", kif.number_out, 1111);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
